// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command-issue slice:
//   - ALU opcode encodings and operand width
//   - issue-controller FSM state encoding
//   - packed command record stored in the command FIFO
//   - signed-overflow helper used when a result is captured
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int OP_W  = 3;
  localparam int CMD_W = 2 * ALU_W + OP_W;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_OUT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
  } cmd_t;

  // Signed overflow from sign bits only. Every opcode other than SUB is an
  // add inside the ALU, so only SUB takes the subtract rule.
  function automatic logic signed_ovf(
    input logic            sa,
    input logic            sb,
    input logic            sr,
    input logic [OP_W-1:0] op
  );
    logic ovf;
    if (op == ALU_SUB) begin
      ovf = (sa != sb) && (sr != sa);
    end else begin
      ovf = (sa == sb) && (sr != sa);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO for packed ALU commands. Overflowing pushes and
// underflowing pops are dropped internally, so callers may drive push/pop
// from raw request signals.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   push, din        write request and data
//   pop, dout        read request; dout shows the head entry (first-word
//                    fall-through)
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 35
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers (wrap naturally at DEPTH, a power of two) and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Command-issue stage in front of a 16-bit add/subtract ALU. Commands are
// buffered in cmd_fifo and issued one at a time; the result (or a watchdog
// error when the ALU never answers) is presented on a valid/ready port.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a, cmd_b, cmd_op        command operands and opcode
//   alu_a, alu_b, alu_op        ALU operands, stable from issue to completion
//   alu_start                   one-cycle start pulse to the ALU
//   alu_out, alu_done           ALU result and completion strobe
//   res_valid/res_ready         result handshake
//   res_data, res_ovf, res_err  result, signed overflow, watchdog timeout
//   busy                        high whenever a command is in flight
//   fifo_count                  command FIFO occupancy
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALU_W-1:0]       cmd_a,
  input  logic [ALU_W-1:0]       cmd_b,
  input  logic [OP_W-1:0]        cmd_op,
  output logic [ALU_W-1:0]       alu_a,
  output logic [ALU_W-1:0]       alu_b,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_start,
  input  logic [ALU_W-1:0]       alu_out,
  input  logic                   alu_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ALU_W-1:0]       res_data,
  output logic                   res_ovf,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  // Watchdog register holds (WAIT cycles elapsed - 1); it fires when the
  // cycle being completed is number TIMEOUT.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e     state_r;
  state_e     state_nx_s;
  logic       issue_s;
  logic       cap_done_s;
  logic       cap_tmo_s;
  logic       release_s;
  logic       push_s;
  logic       full_s;
  logic       empty_s;
  logic       ovf_s;
  logic [7:0] wd_r;
  cmd_t       cmd_in_s;
  cmd_t       head_s;

  assign cmd_in_s  = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_ready = ~full_s;
  assign push_s    = cmd_valid & ~full_s;

  // Overflow is judged against the operands actually held at the ALU.
  assign ovf_s = signed_ovf(alu_a[ALU_W-1], alu_b[ALU_W-1], alu_out[ALU_W-1], alu_op);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (cmd_in_s),
    .pop   (issue_s),
    .dout  (head_s),
    .count (fifo_count),
    .full  (full_s),
    .empty (empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-edge action decode; alu_done only matters in WAIT,
  // and a done on the timeout edge takes priority over the watchdog.
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    cap_done_s = 1'b0;
    cap_tmo_s  = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          issue_s    = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (alu_done) begin
          cap_done_s = 1'b1;
          state_nx_s = ST_OUT;
        end else if (wd_r == WD_LAST) begin
          cap_tmo_s  = 1'b1;
          state_nx_s = ST_OUT;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          release_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // ALU-side registers: operands latched at issue, start pulse, watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      wd_r      <= 8'd0;
    end else begin
      alu_start <= issue_s;
      if (issue_s) begin
        alu_a  <= head_s.a;
        alu_b  <= head_s.b;
        alu_op <= head_s.op;
        wd_r   <= 8'd0;
      end else if (state_r == ST_WAIT) begin
        wd_r <= wd_r + 8'd1;
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  // Result port: captured on completion or timeout, held until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else if (cap_done_s) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_ovf   <= ovf_s;
      res_err   <= 1'b0;
    end else if (cap_tmo_s) begin
      res_valid <= 1'b1;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b1;
    end else if (release_s) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

  // Busy flag registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nx_s != ST_IDLE);
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-issue stage directly upstream of the 16-bit `ALU`. It buffers add/subtract commands in a small FIFO and drives the ALU's `a`, `b`, `alu_op` and `start` inputs one command at a time. It waits for `done`, then presents the result with a signed-overflow flag on a valid/ready output port. A watchdog covers a missing `done`.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `TIMEOUT`, 15: maximum WAIT cycles before declaring error; 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_a` in 16, `cmd_b` in 16: signed operands.
- `cmd_op` in 3: opcode.
- `alu_a` out 16, `alu_b` out 16, `alu_op` out 3: to the ALU, held stable from issue until completion.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_out` in 16 (signed), `alu_done` in 1: from the ALU.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 16: signed result.
- `res_ovf` out 1: signed overflow.
- `res_err` out 1: watchdog timeout.
- `busy` out 1: high in any state other than IDLE.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - `cmd_ready` = occupancy < DEPTH.
  - Push when `cmd_valid && cmd_ready`.
  - Pop only on issue.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, WAIT, OUT.
  - IDLE to WAIT when the FIFO is non-empty. On that edge:
    - pop the head entry;
    - register `alu_a`, `alu_b`, `alu_op`;
    - set `alu_start` = 1 for exactly one cycle;
    - clear the watchdog counter.
  - WAIT to OUT on `alu_done`. On that edge:
    - `res_data` = `alu_out`, `res_ovf` = computed, `res_err` = 0, `res_valid` = 1.
  - WAIT to OUT when the watchdog reaches TIMEOUT with no `alu_done`. On that edge:
    - `res_data` = 0, `res_ovf` = 0, `res_err` = 1, `res_valid` = 1.
  - OUT to IDLE on `res_valid && res_ready`. `res_valid` drops on the same edge.
  - `res_*` outputs are held stable while `res_valid` is high and `res_ready` is low.
- **Overflow rule**
  - Let sa, sb, sr be the sign bits of `alu_a`, `alu_b`, `res_data`.
  - `alu_op` == SUB: ovf = (sa != sb) && (sr != sa).
  - Any other op: ovf = (sa == sb) && (sr != sa). The ALU adds for every non-SUB opcode; such opcodes are forwarded unchanged.
  - Subtracting b = -32768 is flagged per true subtraction. Example: 0 - (-32768) gives `res_data` = -32768, `res_ovf` = 1.
- `alu_done` seen in IDLE or OUT is ignored. This covers a stale done after reset or after a timeout.
- The ALU's own reset is active-high; the integrating top drives it from `!rst`.

## Timing
- **Reset** (`rst` = 0 at an edge):
  - FIFO emptied, `fifo_count` = 0.
  - FSM to IDLE.
  - `alu_a` = `alu_b` = 0, `alu_op` = 0, `alu_start` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_ovf` = 0, `res_err` = 0, `busy` = 0.
  - `cmd_ready` = 1 from the first cycle after reset.
  - Reset mid-WAIT abandons the command with no result.
- **Latency**, empty FIFO, ALU done one cycle after start:
  - Command accepted at edge E0.
  - Issue at E1 (`alu_start` high during E1–E2).
  - ALU samples at E2; `alu_done` high during E2–E3.
  - Captured at E3, so `res_valid` rises 3 cycles after acceptance.
- **Throughput:** one command per 4 cycles with `res_ready` held high (IDLE, WAIT ×2, OUT).
- **Watchdog:** counts cycles in WAIT from 1. It fires on the edge where the count equals TIMEOUT and `alu_done` is low. `alu_done` on that same edge wins.

## Structure
- Shared package `alu_pkg`:
  - `ALU_ADD` = 3'b000, `ALU_SUB` = 3'b001.
  - `ALU_W` = 16.
  - State encoding for IDLE/WAIT/OUT.
- Sub-module `cmd_fifo`: parameterised synchronous FIFO of {a, b, op}, 35 bits. Provides `count`, `full`, `empty`.
- FSM, watchdog and overflow logic live in `alu_issue_ctrl`.

## Test plan
- **Add:** push a=100, b=23, op=ADD, with a 1-cycle-latency ALU model and `res_ready` = 1.
  - `alu_start` pulses once.
  - `res_data` = 123, `res_ovf` = 0, `res_valid` 3 cycles after acceptance.
- **Overflow:**
  - ADD 32767 + 1 gives -32768 with ovf = 1.
  - SUB -32768 - 1 gives 32767 with ovf = 1.
  - SUB 0 - (-32768) gives -32768 with ovf = 1.
  - SUB 5 - 7 gives -2 with ovf = 0.
- **Full FIFO / backpressure:** hold `res_ready` = 0 and push 6 commands.
  - `cmd_ready` drops after 5 accepted: 1 in flight plus 4 buffered.
  - Release `res_ready`; results emerge in order and `fifo_count` drains to 0.
- **Timeout:** ALU model never asserts done.
  - After 15 WAIT cycles: `res_err` = 1, `res_data` = 0.
  - A late done pulse while in OUT or IDLE has no effect.
  - The next command completes normally.
- **Reset mid-operation:** assert `rst` = 0 for 1 cycle while in WAIT with 2 commands queued.
  - All outputs return to reset values and `fifo_count` = 0.
  - The ALU's done on the next cycle is ignored and no `res_valid` appears.
